// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one register command into a full I2C bus transaction
// on the byte-level master engine (write: dev/reg/data, read: dev/reg/rs/dev/data).
module i2c_reg_seq #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int I2C_FREQ    = 100_000,
  parameter int GUARD_CYC   = 2*CLK_FREQ/I2C_FREQ,
  parameter int TIMEOUT_CYC = 16*CLK_FREQ/I2C_FREQ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [1:0] rsp_status,
  output logic [7:0] rsp_rdata,
  output logic       i2c_start,
  output logic       i2c_stop,
  output logic [7:0] i2c_wr_data,
  input  logic [1:0] i2c_ack,
  input  logic       i2c_rd_tick,
  input  logic [7:0] i2c_rd_data
);

  localparam int CW = $clog2(TIMEOUT_CYC + GUARD_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, DEV, REG, DATA, RADDR, RDATA, GUARD
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        rv_q, rv_d;
  logic [1:0]  st_q, st_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        start_q, start_d;
  logic        stopr_q, stopr_d;
  logic [7:0]  wr_q, wr_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wd_q, wd_d;
  logic        evt, tmo;

  assign evt = i2c_ack[1] | i2c_rd_tick;
  assign tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    rv_d    = 1'b0;
    st_d    = st_q;
    rdata_d = rdata_q;
    start_d = 1'b0;
    stopr_d = stopr_q;
    wr_d    = wr_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wd_d    = wd_q;
    if (state_q != IDLE && state_q != GUARD)
      cnt_d = evt ? '0 : cnt_q + CW'(1);
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          ready_d = 1'b0;
          rw_d    = cmd_rw;
          dev_d   = cmd_dev;
          reg_d   = cmd_reg;
          wd_d    = cmd_wdata;
          st_d    = 2'b00;
          wr_d    = {cmd_dev, 1'b0};
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = DEV;
        end
      end
      DEV: begin
        if (i2c_ack[1]) begin
          if (!i2c_ack[0]) begin
            st_d    = 2'b01;
            state_d = GUARD;
          end else begin
            wr_d    = reg_q;
            state_d = REG;
          end
        end else if (tmo) begin
          st_d    = 2'b11;
          stopr_d = 1'b1;
          state_d = GUARD;
        end
      end
      REG: begin
        if (i2c_ack[1]) begin
          if (!i2c_ack[0]) begin
            st_d    = 2'b10;
            state_d = GUARD;
          end else if (rw_q) begin
            start_d = 1'b1;
            wr_d    = {dev_q, 1'b1};
            state_d = RADDR;
          end else begin
            wr_d    = wd_q;
            state_d = DATA;
          end
        end else if (tmo) begin
          st_d    = 2'b11;
          stopr_d = 1'b1;
          state_d = GUARD;
        end
      end
      DATA: begin
        if (i2c_ack[1]) begin
          stopr_d = 1'b1;
          st_d    = i2c_ack[0] ? 2'b00 : 2'b10;
          state_d = GUARD;
        end else if (tmo) begin
          st_d    = 2'b11;
          stopr_d = 1'b1;
          state_d = GUARD;
        end
      end
      RADDR: begin
        start_d = 1'b1;
        if (i2c_ack[1]) begin
          start_d = 1'b0;
          if (!i2c_ack[0]) begin
            st_d    = 2'b01;
            state_d = GUARD;
          end else begin
            // stop held high before the byte so the engine reads just one
            stopr_d = 1'b1;
            state_d = RDATA;
          end
        end else if (tmo) begin
          start_d = 1'b0;
          st_d    = 2'b11;
          stopr_d = 1'b1;
          state_d = GUARD;
        end
      end
      RDATA: begin
        if (i2c_rd_tick) begin
          rdata_d = i2c_rd_data;
          st_d    = 2'b00;
          state_d = GUARD;
        end else if (tmo) begin
          st_d    = 2'b11;
          stopr_d = 1'b1;
          state_d = GUARD;
        end
      end
      GUARD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(GUARD_CYC - 1)) begin
          rv_d    = 1'b1;
          stopr_d = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GUARD && state_q != GUARD)
      cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      rv_q    <= 1'b0;
      st_q    <= 2'b00;
      rdata_q <= 8'h00;
      start_q <= 1'b0;
      stopr_q <= 1'b0;
      wr_q    <= 8'h00;
      rw_q    <= 1'b0;
      dev_q   <= 7'h00;
      reg_q   <= 8'h00;
      wd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rv_q    <= rv_d;
      st_q    <= st_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
      stopr_q <= stopr_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wd_q    <= wd_d;
    end
  end

  // NACK term is combinational so the engine sees stop on the ack tick itself
  assign i2c_stop    = stopr_q | (i2c_ack[1] & ~i2c_ack[0]);
  assign cmd_ready   = ready_q;
  assign rsp_valid   = rv_q;
  assign rsp_status  = st_q;
  assign rsp_rdata   = rdata_q;
  assign i2c_start   = start_q;
  assign i2c_wr_data = wr_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb_i2c_reg_seq: directed bench for i2c_reg_seq with a hand-driven
// engine stub (ack ticks and read ticks issued by the stimulus).
module tb_i2c_reg_seq;

  localparam int G = 20;
  localparam int T = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_dev = 7'h00;
  logic [7:0] cmd_reg = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [7:0] rsp_rdata;
  logic       i2c_start;
  logic       i2c_stop;
  logic [7:0] i2c_wr_data;
  logic [1:0] i2c_ack = 2'b00;
  logic       i2c_rd_tick = 1'b0;
  logic [7:0] i2c_rd_data = 8'h00;

  int total = 0;
  int bad = 0;
  int npulse = 0;
  int nrise = 0;
  logic stop_prev = 1'b0;

  i2c_reg_seq #(
    .CLK_FREQ(1000), .I2C_FREQ(100),
    .GUARD_CYC(G), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_dev(cmd_dev),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_rdata(rsp_rdata),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .i2c_wr_data(i2c_wr_data), .i2c_ack(i2c_ack),
    .i2c_rd_tick(i2c_rd_tick), .i2c_rd_data(i2c_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (rsp_valid) npulse++;
    if (i2c_stop && !stop_prev) nrise++;
    stop_prev = i2c_stop;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic rw, input logic [6:0] dev,
                       input logic [7:0] rg, input logic [7:0] wd);
    chk("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_drop", cmd_ready, 0);
    chk("start_pulse", i2c_start, 1);
  endtask

  task automatic tick(input logic a, output logic stop_seen);
    cyc(3);
    i2c_ack = {1'b1, a};
    #1 stop_seen = i2c_stop;
    @(negedge clk);
    i2c_ack = 2'b00;
  endtask

  task automatic finish_txn(input logic [1:0] st);
    int n;
    int rv_at;
    int p0;
    n = 0; rv_at = -1; p0 = npulse;
    while (!cmd_ready && n < 500) begin
      if (rsp_valid) begin
        rv_at = n;
        chk("status", rsp_status, st);
      end
      cyc(1);
      n++;
    end
    chk("ready_lat", n, G + 1);
    chk("rsp_at", rv_at, G);
    chk("pulses", npulse - p0, 1);
    chk("stop_clear", i2c_stop, 0);
  endtask

  initial begin
    logic s;
    int n;
    int r0;
    cyc(2);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_start", i2c_start, 0);
    chk("rst_stop", i2c_stop, 0);
    chk("rst_wr", i2c_wr_data, 0);
    rst = 1'b0;
    cyc(2);

    // write, all ACK
    issue(1'b0, 7'h3C, 8'h10, 8'hA5);
    chk("w_dev", i2c_wr_data, 8'h78);
    tick(1'b1, s);
    chk("w_reg", i2c_wr_data, 8'h10);
    chk("w_start_low", i2c_start, 0);
    tick(1'b1, s);
    chk("w_data", i2c_wr_data, 8'hA5);
    tick(1'b1, s);
    chk("w_stop", i2c_stop, 1);
    finish_txn(2'b00);

    // read, returns 0x5A
    issue(1'b1, 7'h3C, 8'h20, 8'h00);
    chk("r_dev", i2c_wr_data, 8'h78);
    tick(1'b1, s);
    chk("r_reg", i2c_wr_data, 8'h20);
    tick(1'b1, s);
    chk("r_rs", i2c_start, 1);
    chk("r_devr", i2c_wr_data, 8'h79);
    tick(1'b1, s);
    chk("r_ack_stop", s, 0);
    chk("r_start_low", i2c_start, 0);
    cyc(2);
    i2c_rd_tick = 1'b1; i2c_rd_data = 8'h5A;
    #1 chk("r_stop_rd", i2c_stop, 1);
    @(negedge clk);
    i2c_rd_tick = 1'b0;
    finish_txn(2'b00);
    chk("r_data", rsp_rdata, 8'h5A);

    // address NACK
    issue(1'b0, 7'h11, 8'h10, 8'hA5);
    chk("an_dev", i2c_wr_data, 8'h22);
    tick(1'b0, s);
    chk("an_stop", s, 1);
    chk("an_nobyte", i2c_wr_data, 8'h22);
    finish_txn(2'b01);

    // data NACK
    r0 = nrise;
    issue(1'b0, 7'h3C, 8'h10, 8'hA5);
    tick(1'b1, s);
    tick(1'b1, s);
    tick(1'b0, s);
    chk("dn_stop", s, 1);
    finish_txn(2'b10);
    chk("dn_rises", nrise - r0, 1);

    // timeout, with ignored commands while busy
    issue(1'b0, 7'h3C, 8'h10, 8'hA5);
    n = 0;
    while (!i2c_stop && n < 1000) begin
      cmd_valid = (n < 5); cmd_dev = 7'h55;
      if (n == 4) chk("busy_ready", cmd_ready, 0);
      cyc(1);
      n++;
    end
    cmd_valid = 1'b0;
    chk("to_lat", n, T);
    chk("to_wr", i2c_wr_data, 8'h78);
    finish_txn(2'b11);

    // reset during RDATA
    issue(1'b1, 7'h3C, 8'h20, 8'h00);
    tick(1'b1, s);
    tick(1'b1, s);
    tick(1'b1, s);
    cyc(2);
    rst = 1'b1;
    #1;
    chk("ar_ready", cmd_ready, 1);
    chk("ar_stop", i2c_stop, 0);
    chk("ar_start", i2c_start, 0);
    chk("ar_wr", i2c_wr_data, 0);
    chk("ar_rdata", rsp_rdata, 0);
    chk("ar_st", rsp_status, 0);
    cyc(3);
    rst = 1'b0;
    cyc(1);
    issue(1'b0, 7'h3C, 8'h10, 8'hA5);
    tick(1'b1, s);
    tick(1'b1, s);
    tick(1'b1, s);
    finish_txn(2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
